id_ex_stage_reg: RTL and testbench
==================================

# id_ex_stage_reg

Parametrised ID/EX pipeline stage register for the pipelined RV32I core. It carries decoded control and operand data from decode to execute with valid/ready flow control, an optional skid buffer, synchronous flush and automatic bubble (NOP) insertion. It replaces the plain always-loading decode-stage register, so stalls and branch flushes are handled inside the stage instead of by external muxing.

## Interface
- XLEN, 32, width of operand, PC and instruction fields
- ALU_W, 4, width of ALU control field
- WB_W, 2, width of mem-to-reg (writeback select) field
- SKID, 1, 0 = single register (combinational in_ready); 1 = main + skid register (registered in_ready)
- NOP_INSTR, 32'h0000_0013, instruction word driven for a bubble (addi x0,x0,0)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous kill of all held and incoming entries
- in_valid  in  1  decode presents a valid entry
- in_ready  out  1  stage can accept this cycle
- load_in, store_in, next_sel_in, branch_result_in  in  1 each  control bits
- alu_control_in  in  ALU_W  ALU operation
- mem_to_reg_in  in  WB_W  writeback select
- opa_mux_in, opb_mux_in, opb_data_in  in  XLEN each  operand A, operand B, store data
- pre_address_in, instruction_in  in  XLEN each  PC of instruction, instruction word
- out_valid  out  1  execute-side entry valid
- out_ready  in  1  execute accepts this cycle
- load, store, next_sel, branch_result, alu_control, mem_to_reg, opa_mux_out, opb_mux_out, opb_data_out, pre_address_out, instruction_out  out  as inputs  registered payload

## Operation
- Bubble value: all control bits 0, alu_control 0, mem_to_reg 0, operands/PC 0, instruction NOP_INSTR.
- Accept = in_valid && in_ready && !flush. Transfer-out = out_valid && out_ready.
- SKID=0: in_ready = !out_valid || out_ready. On accept, main <= input, out_valid <= 1. Transfer-out without accept: main <= bubble, out_valid <= 0. Otherwise hold.
- SKID=1: states EMPTY (main empty), ONE (main full), TWO (main + skid full). in_ready = (state != TWO), driven from a flop.
  - EMPTY: accept -> main <= input, ONE.
  - ONE: accept && transfer-out -> main <= input, ONE; accept only -> skid <= input, TWO; transfer-out only -> main <= bubble, EMPTY.
  - TWO: transfer-out -> main <= skid, skid <= bubble, ONE; input ignored (in_ready=0).
- flush has highest priority: next cycle main and skid hold bubble, out_valid 0, state EMPTY, in_ready 1; a same-cycle input is dropped; a same-cycle transfer-out still completes.
- Outputs always reflect main register; when out_valid=0, outputs equal the bubble value.
- Order preserved; no entry duplicated or lost except by flush.

## Timing
- Reset (async assert, sync release): out_valid 0, in_ready 1, all payload outputs = bubble, state EMPTY.
- Latency: accepted entry appears on outputs the cycle after acceptance.
- Throughput: 1 entry/cycle with out_ready held 1, both SKID settings.
- SKID=1: in_ready depends only on flops (no in/out combinational path); in_ready drops the cycle after an entry enters skid, rises the cycle after skid drains.
- SKID=0: in_ready combinationally follows out_ready.
- Reset mid-stream: all entries discarded immediately, no partial update.

## Test plan
- Reset: rst_n low with in_valid=1, instruction_in=32'h00500093 -> out_valid 0, instruction_out 32'h00000013, in_ready 1; release, one accept -> next cycle instruction_out 32'h00500093, out_valid 1.
- Streaming: out_ready=1, 8 back-to-back entries with pre_address_in 0,4,...,28 -> outputs 0..28 on consecutive cycles, 1 cycle latency, no gaps.
- Stall (SKID=1): out_ready=0 with entries A(PC 0x10), B(0x14), C(0x18) offered -> A on outputs, B in skid, in_ready 0, C held by decode; out_ready=1 -> A, B, C emerge in order on consecutive cycles.
- Flush in TWO: stage holds A,B, flush=1 with in_valid=1 (C) -> next cycle out_valid 0, load/store 0, instruction_out NOP, in_ready 1; C never appears.
- Drain to bubble: single entry alu_control_in 4'b0110, load_in 1, then in_valid 0 and out_ready 1 -> cycle after transfer: out_valid 0, alu_control 0, load 0.
- SKID=0 variant: out_ready=0 with out_valid=1 -> in_ready 0 same cycle; out_ready=1 -> in_ready 1 same cycle, payload replaced next edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline stage register with valid/ready flow control.
//
// Carries decoded control and operand data from decode to execute. Supports
// synchronous flush, automatic bubble (NOP) insertion when empty, and an
// optional skid buffer that makes in_ready a pure flop output.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   flush                synchronous kill of held and incoming entries
//   in_valid / in_ready  decode-side handshake
//   *_in                 decoded payload from decode
//   out_valid / out_ready execute-side handshake
//   load .. instruction_out  registered payload (bubble when out_valid=0)
module id_ex_stage_reg #(
  parameter int unsigned     XLEN      = 32,
  parameter int unsigned     ALU_W     = 4,
  parameter int unsigned     WB_W      = 2,
  parameter int unsigned     SKID      = 1,
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             load_in,
  input  logic             store_in,
  input  logic             next_sel_in,
  input  logic             branch_result_in,
  input  logic [ALU_W-1:0] alu_control_in,
  input  logic [WB_W-1:0]  mem_to_reg_in,
  input  logic [XLEN-1:0]  opa_mux_in,
  input  logic [XLEN-1:0]  opb_mux_in,
  input  logic [XLEN-1:0]  opb_data_in,
  input  logic [XLEN-1:0]  pre_address_in,
  input  logic [XLEN-1:0]  instruction_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             load,
  output logic             store,
  output logic             next_sel,
  output logic             branch_result,
  output logic [ALU_W-1:0] alu_control,
  output logic [WB_W-1:0]  mem_to_reg,
  output logic [XLEN-1:0]  opa_mux_out,
  output logic [XLEN-1:0]  opb_mux_out,
  output logic [XLEN-1:0]  opb_data_out,
  output logic [XLEN-1:0]  pre_address_out,
  output logic [XLEN-1:0]  instruction_out
);

  localparam int unsigned PW = 4 + ALU_W + WB_W + 5 * XLEN;
  typedef logic [PW-1:0] payload_t;

  localparam payload_t Bubble = {4'b0000, {ALU_W{1'b0}}, {WB_W{1'b0}}, {(4 * XLEN){1'b0}},
                                 NOP_INSTR};

  payload_t in_pl;
  payload_t main_q, main_d;
  logic     accept, xfer;

  assign in_pl = {load_in, store_in, next_sel_in, branch_result_in, alu_control_in,
                  mem_to_reg_in, opa_mux_in, opb_mux_in, opb_data_in, pre_address_in,
                  instruction_in};

  assign {load, store, next_sel, branch_result, alu_control, mem_to_reg, opa_mux_out,
          opb_mux_out, opb_data_out, pre_address_out, instruction_out} = main_q;

  assign accept = in_valid && in_ready && !flush;
  assign xfer   = out_valid && out_ready;

  if (SKID == 0) begin : g_single
    logic valid_q, valid_d;

    // Combinational ready: a full register frees up when execute takes it.
    assign in_ready  = !valid_q || out_ready;
    assign out_valid = valid_q;

    always_comb begin
      main_d  = main_q;
      valid_d = valid_q;
      if (flush) begin
        main_d  = Bubble;
        valid_d = 1'b0;
      end else if (accept) begin
        main_d  = in_pl;
        valid_d = 1'b1;
      end else if (xfer) begin
        main_d  = Bubble;
        valid_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        main_q  <= Bubble;
        valid_q <= 1'b0;
      end else begin
        main_q  <= main_d;
        valid_q <= valid_d;
      end
    end
  end else begin : g_skid
    typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

    state_e   state_q, state_d;
    payload_t skid_q, skid_d;
    logic     in_ready_q;

    // Ready is registered from the next state so no in/out combinational path.
    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);

    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = StEmpty;
        main_d  = Bubble;
        skid_d  = Bubble;
      end else begin
        case (state_q)
          StEmpty: begin
            if (accept) begin
              main_d  = in_pl;
              state_d = StOne;
            end
          end
          StOne: begin
            if (accept && xfer) begin
              main_d = in_pl;
            end else if (accept) begin
              skid_d  = in_pl;
              state_d = StTwo;
            end else if (xfer) begin
              main_d  = Bubble;
              state_d = StEmpty;
            end
          end
          StTwo: begin
            if (xfer) begin
              main_d  = skid_q;
              skid_d  = Bubble;
              state_d = StOne;
            end
          end
          default: begin
            state_d = StEmpty;
            main_d  = Bubble;
            skid_d  = Bubble;
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= StEmpty;
        main_q     <= Bubble;
        skid_q     <= Bubble;
        in_ready_q <= 1'b1;
      end else begin
        state_q    <= state_d;
        main_q     <= main_d;
        skid_q     <= skid_d;
        in_ready_q <= (state_d != StTwo);
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
module tb_id_ex_stage_reg;
  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic        load_in, store_in, next_sel_in, branch_result_in;
  logic [3:0]  alu_control_in;
  logic [1:0]  mem_to_reg_in;
  logic [31:0] opa_mux_in, opb_mux_in, opb_data_in, pre_address_in, instruction_in;

  // SKID=1 instance
  logic        in_ready1, out_valid1, load1, store1, next_sel1, branch_result1;
  logic [3:0]  alu_control1;
  logic [1:0]  mem_to_reg1;
  logic [31:0] opa1, opb1, opbd1, pc1, instr1;
  // SKID=0 instance
  logic        in_ready0, out_valid0, load0, store0, next_sel0, branch_result0;
  logic [3:0]  alu_control0;
  logic [1:0]  mem_to_reg0;
  logic [31:0] opa0, opb0, opbd0, pc0, instr0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_stage_reg #(.SKID(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .load_in(load_in), .store_in(store_in), .next_sel_in(next_sel_in),
    .branch_result_in(branch_result_in), .alu_control_in(alu_control_in),
    .mem_to_reg_in(mem_to_reg_in), .opa_mux_in(opa_mux_in), .opb_mux_in(opb_mux_in),
    .opb_data_in(opb_data_in), .pre_address_in(pre_address_in),
    .instruction_in(instruction_in), .out_valid(out_valid1), .out_ready(out_ready),
    .load(load1), .store(store1), .next_sel(next_sel1), .branch_result(branch_result1),
    .alu_control(alu_control1), .mem_to_reg(mem_to_reg1), .opa_mux_out(opa1),
    .opb_mux_out(opb1), .opb_data_out(opbd1), .pre_address_out(pc1), .instruction_out(instr1)
  );

  id_ex_stage_reg #(.SKID(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .load_in(load_in), .store_in(store_in), .next_sel_in(next_sel_in),
    .branch_result_in(branch_result_in), .alu_control_in(alu_control_in),
    .mem_to_reg_in(mem_to_reg_in), .opa_mux_in(opa_mux_in), .opb_mux_in(opb_mux_in),
    .opb_data_in(opb_data_in), .pre_address_in(pre_address_in),
    .instruction_in(instruction_in), .out_valid(out_valid0), .out_ready(out_ready),
    .load(load0), .store(store0), .next_sel(next_sel0), .branch_result(branch_result0),
    .alu_control(alu_control0), .mem_to_reg(mem_to_reg0), .opa_mux_out(opa0),
    .opb_mux_out(opb0), .opb_data_out(opbd0), .pre_address_out(pc0), .instruction_out(instr0)
  );

  // Drive one entry's payload; PC also tags the operands so order is visible.
  task automatic set_in(input logic v, input logic [31:0] pc);
    in_valid       = v;
    pre_address_in = pc;
    opa_mux_in     = pc + 32'h1000;
    opb_mux_in     = pc + 32'h2000;
    opb_data_in    = pc + 32'h3000;
    instruction_in = {pc[19:0], 12'h093};
  endtask

  task automatic test_reset;
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    load_in = 1'b0; store_in = 1'b0; next_sel_in = 1'b0; branch_result_in = 1'b0;
    alu_control_in = 4'h0; mem_to_reg_in = 2'h0;
    set_in(1'b1, 32'h0);
    instruction_in = 32'h00500093;
    repeat (2) @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", out_valid1); end
    checks++; if (instr1 !== 32'h13) begin failures++; $display("FAIL reset_instr got %h want 00000013", instr1); end
    checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", in_ready1); end
    checks++; if (pc1 !== 32'h0 || opa1 !== 32'h0 || alu_control1 !== 4'h0) begin failures++; $display("FAIL reset_payload got pc=%h opa=%h alu=%h want 0", pc1, opa1, alu_control1); end
    checks++; if (out_valid0 !== 1'b0 || instr0 !== 32'h13) begin failures++; $display("FAIL reset_skid0 got v=%b instr=%h want 0/00000013", out_valid0, instr0); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (instr1 !== 32'h00500093 || out_valid1 !== 1'b1) begin failures++; $display("FAIL reset_first_accept got v=%b instr=%h want 1/00500093", out_valid1, instr1); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_drain got %b want 0", out_valid1); end
  endtask

  task automatic test_stream;
    out_ready = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        checks++;
        if (out_valid1 !== 1'b1 || pc1 !== 32'(4 * (i - 1)) || in_ready1 !== 1'b1) begin
          failures++;
          $display("FAIL stream_%0d got v=%b pc=%h rdy=%b want 1/%h/1", i - 1, out_valid1, pc1, in_ready1, 32'(4 * (i - 1)));
        end
      end
      if (i < 8) set_in(1'b1, 32'(4 * i));
      else in_valid = 1'b0;
      @(negedge clk);
    end
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL stream_end got %b want 0", out_valid1); end
  endtask

  task automatic test_stall;
    out_ready = 1'b0;
    set_in(1'b1, 32'h10);
    @(negedge clk);
    checks++; if (pc1 !== 32'h10 || out_valid1 !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL stall_a got pc=%h v=%b rdy=%b want 10/1/1", pc1, out_valid1, in_ready1); end
    set_in(1'b1, 32'h14);
    @(negedge clk);
    checks++; if (pc1 !== 32'h10 || in_ready1 !== 1'b0) begin failures++; $display("FAIL stall_b_skid got pc=%h rdy=%b want 10/0", pc1, in_ready1); end
    set_in(1'b1, 32'h18);
    @(negedge clk);
    checks++; if (pc1 !== 32'h10 || in_ready1 !== 1'b0) begin failures++; $display("FAIL stall_hold got pc=%h rdy=%b want 10/0", pc1, in_ready1); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (pc1 !== 32'h14 || out_valid1 !== 1'b1 || in_ready1 !== 1'b1) begin failures++; $display("FAIL stall_out_b got pc=%h v=%b rdy=%b want 14/1/1", pc1, out_valid1, in_ready1); end
    @(negedge clk);
    checks++; if (pc1 !== 32'h18 || out_valid1 !== 1'b1 || opa1 !== 32'h1018) begin failures++; $display("FAIL stall_out_c got pc=%h v=%b opa=%h want 18/1/1018", pc1, out_valid1, opa1); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL stall_drain got %b want 0", out_valid1); end
  endtask

  task automatic test_flush_two;
    out_ready = 1'b0; load_in = 1'b1; store_in = 1'b1;
    set_in(1'b1, 32'h20);
    @(negedge clk);
    set_in(1'b1, 32'h24);
    @(negedge clk);
    checks++; if (in_ready1 !== 1'b0 || load1 !== 1'b1) begin failures++; $display("FAIL flush_pre got rdy=%b load=%b want 0/1", in_ready1, load1); end
    flush = 1'b1;
    set_in(1'b1, 32'h28);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; load_in = 1'b0; store_in = 1'b0;
    checks++; if (out_valid1 !== 1'b0 || load1 !== 1'b0 || store1 !== 1'b0) begin failures++; $display("FAIL flush_ctrl got v=%b ld=%b st=%b want 0/0/0", out_valid1, load1, store1); end
    checks++; if (instr1 !== 32'h13 || pc1 !== 32'h0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL flush_bubble got instr=%h pc=%h rdy=%b want 00000013/0/1", instr1, pc1, in_ready1); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL flush_no_ghost_%0d got v=%b pc=%h want 0", i, out_valid1, pc1); end
    end
  endtask

  task automatic test_drain_bubble;
    out_ready = 1'b0; load_in = 1'b1; alu_control_in = 4'b0110;
    set_in(1'b1, 32'h30);
    @(negedge clk);
    checks++; if (alu_control1 !== 4'b0110 || load1 !== 1'b1 || out_valid1 !== 1'b1) begin failures++; $display("FAIL drain_load got alu=%h ld=%b v=%b want 6/1/1", alu_control1, load1, out_valid1); end
    in_valid = 1'b0; out_ready = 1'b1; load_in = 1'b0; alu_control_in = 4'h0;
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0 || alu_control1 !== 4'h0 || load1 !== 1'b0 || instr1 !== 32'h13) begin failures++; $display("FAIL drain_bubble got v=%b alu=%h ld=%b instr=%h want 0/0/0/00000013", out_valid1, alu_control1, load1, instr1); end
  endtask

  task automatic test_skid0;
    flush = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 32'h40);
    #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL skid0_empty_ready got %b want 1", in_ready0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1 || pc0 !== 32'h40) begin failures++; $display("FAIL skid0_load got v=%b pc=%h want 1/40", out_valid0, pc0); end
    set_in(1'b1, 32'h44);
    #1;
    checks++; if (in_ready0 !== 1'b0) begin failures++; $display("FAIL skid0_stall_ready got %b want 0", in_ready0); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL skid0_comb_ready got %b want 1", in_ready0); end
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b1 || pc0 !== 32'h44) begin failures++; $display("FAIL skid0_replace got v=%b pc=%h want 1/44", out_valid0, pc0); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid0 !== 1'b0 || instr0 !== 32'h13) begin failures++; $display("FAIL skid0_drain got v=%b instr=%h want 0/00000013", out_valid0, instr0); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    set_in(1'b1, 32'h50);
    @(negedge clk);
    set_in(1'b1, 32'h54);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid1 !== 1'b0 || pc1 !== 32'h0 || in_ready1 !== 1'b1) begin failures++; $display("FAIL midreset got v=%b pc=%h rdy=%b want 0/0/1", out_valid1, pc1, in_ready1); end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin failures++; $display("FAIL midreset_empty got v1=%b v0=%b want 0/0", out_valid1, out_valid0); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush_two();
    test_drain_bubble();
    test_skid0();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
